// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit: op codes, FSM states, iteration count.
package mdu_pkg;

  localparam int MDU_ITER = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_FIX  = 2'b10;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement (dout = neg ? -din : din); combinational, zero latency, no flow control.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; divider built only with MDU_DIV_EN.
// Latency: done rises ITER+2 edges from acceptance (accepting edge counted); start ignored while busy.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int ITER = MDU_ITER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(ITER + 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic          a_sign_q;
  logic          b_sign_q;
  logic [31:0]   opd_q;
  logic [63:0]   acc;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [32:0]   msum;
  logic [63:0]   mul_next;
  logic [63:0]   calc_next;
  logic [63:0]   prod_fix;
  logic          prod_neg;

  assign busy = (state != ST_IDLE);

  mdu_sign_fix #(.W(32)) u_mag_a (.din(a), .neg(op[0] & a[31]), .dout(mag_a));
  mdu_sign_fix #(.W(32)) u_mag_b (.din(b), .neg(op[0] & b[31]), .dout(mag_b));

  // Multiplier sits in acc[31:0] and shifts out LSB-first while the partial product grows in acc[63:32].
  assign msum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd_q} : 33'd0);
  assign mul_next = {msum, acc[31:1]};

  assign prod_neg = (op_q == OP_MULT) & (a_sign_q ^ b_sign_q);
  mdu_sign_fix #(.W(64)) u_prod (.din(acc), .neg(prod_neg), .dout(prod_fix));

`ifdef MDU_DIV_EN
  logic [31:0] a_q;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] rem_sub;
  logic [63:0] div_next;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Restoring divide: acc = {partial remainder, dividend bits that become quotient bits}.
  assign shifted  = {acc[63:32], acc[31]};
  assign ge       = (shifted >= {1'b0, opd_q});
  assign rem_sub  = shifted[31:0] - opd_q;
  assign div_next = ge ? {rem_sub, acc[30:0], 1'b1} : {shifted[31:0], acc[30:0], 1'b0};
  assign calc_next = op_q[1] ? div_next : mul_next;

  mdu_sign_fix #(.W(32)) u_quo (
    .din(acc[31:0]), .neg((op_q == OP_DIV) & (a_sign_q ^ b_sign_q)), .dout(quo_fix));
  mdu_sign_fix #(.W(32)) u_rem (
    .din(acc[63:32]), .neg((op_q == OP_DIV) & a_sign_q), .dout(rem_fix));
`else
  assign calc_next = mul_next;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      opd_q    <= '0;
      acc      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MDU_DIV_EN
      a_q      <= '0;
`endif
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      // Register writes land first so a completing result in FIX overrides them.
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q     <= op;
            a_sign_q <= a[31];
            b_sign_q <= b[31];
            opd_q    <= op[1] ? mag_b : mag_a;
            acc      <= {32'd0, (op[1] ? mag_a : mag_b)};
            cnt      <= '0;
`ifdef MDU_DIV_EN
            a_q      <= a;
            state    <= ST_CALC;
`else
            state    <= op[1] ? ST_FIX : ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          acc <= calc_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(ITER - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          state <= ST_IDLE;
          done  <= 1'b1;
          if (!op_q[1]) begin
            {hi, lo} <= prod_fix;
          end
`ifdef MDU_DIV_EN
          else if (opd_q == '0) begin
            hi       <= a_q;
            lo       <= '1;
            div_zero <= 1'b1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed corner cases then random ops against an arithmetic reference model.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;
  logic        dz_exp = 1'b0;

  always #5 clk = ~clk;

  mdu_iter #(.ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural model: HI/LO state updated with plain 64-bit arithmetic.
  task automatic ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sa;
    longint sb;
    longint p;
    dz_exp = 1'b0;
    sa = $signed(x);
    sb = $signed(y);
    case (o)
      OP_MULTU: {ref_hi, ref_lo} = {32'd0, x} * {32'd0, y};
      OP_MULT: begin
        p = sa * sb;
        {ref_hi, ref_lo} = p;
      end
      default: begin
`ifdef MDU_DIV_EN
        if (y == 32'd0) begin
          ref_hi = x;
          ref_lo = 32'hFFFF_FFFF;
          dz_exp = 1'b1;
        end else if (o == OP_DIVU) begin
          ref_lo = x / y;
          ref_hi = x % y;
        end else begin
          ref_lo = 32'(sa / sb);
          ref_hi = 32'(sa % sb);
        end
`endif
      end
    endcase
  endtask

  function automatic int exp_lat(input logic [1:0] o);
`ifdef MDU_DIV_EN
    return 34;
`else
    return o[1] ? 2 : 34;
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom();
    endcase
  endfunction

  // Presents one op; lat counts edges from the accepting edge (inclusive) to the edge raising done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    check("busy_after_accept", busy, 1);
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic exec(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    int lat;
    ref_op(o, x, y);
    run_op(o, x, y, lat);
    check({tag, "_lat"}, lat, exp_lat(o));
    check({tag, "_hi"}, hi, ref_hi);
    check({tag, "_lo"}, lo, ref_lo);
    check({tag, "_dz"}, div_zero, dz_exp);
    check({tag, "_busy_done"}, busy, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_dz_clear"}, div_zero, 0);
  endtask

  initial begin
    int n;
    logic saw_done;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst = 1'b1;

    exec(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_max_hi_k", hi, 32'hFFFF_FFFE);
    check("multu_max_lo_k", lo, 32'h0000_0001);

    exec(OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    check("mult_neg_hi_k", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo_k", lo, 32'hFFFF_FFEB);

`ifdef MDU_DIV_EN
    exec(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    check("div_m7_2_lo_k", lo, 32'hFFFF_FFFD);
    check("div_m7_2_hi_k", hi, 32'hFFFF_FFFF);
    exec(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_lo_k", lo, 32'h8000_0000);
    check("div_ovf_hi_k", hi, 32'h0000_0000);
    exec(OP_DIVU, 32'd100, 32'd0, "divu_zero");
    check("divu_zero_lo_k", lo, 32'hFFFF_FFFF);
    check("divu_zero_hi_k", hi, 32'h0000_0064);
`else
    exec(OP_DIVU, 32'd100, 32'd0, "divu_nodiv");
    check("divu_nodiv_hi_k", hi, 32'hFFFF_FFFF);
    check("divu_nodiv_lo_k", lo, 32'hFFFF_FFEB);
`endif

    // Second start while busy is dropped; MTHI mid-operation is visible until FIX.
    ref_op(OP_MULTU, 32'd5, 32'd6);
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0; n = 1;
    repeat (3) @(negedge clk);
    n = 4;
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd0;
    @(negedge clk);
    start = 1'b0; n = 5;
    check("busy_ignore_busy", busy, 1);
    repeat (4) @(negedge clk);
    n = 9;
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0; n = 10;
    check("mthi_mid_hi", hi, 32'h1234);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ignore_lat", n, 34);
    check("ignore_hi", hi, ref_hi);
    check("ignore_lo", lo, ref_lo);
    repeat (3) @(negedge clk);
    check("ignore_no_queue", busy, 0);

    // MTLO on the accepting edge applies, then the product overwrites it.
    ref_op(OP_MULTU, 32'd3, 32'd4);
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd4; lo_we = 1'b1; wdata = 32'd77;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0; n = 1;
    check("mtlo_start_lo", lo, 32'd77);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mtlo_start_lat", n, 34);
    check("mtlo_start_final", lo, ref_lo);

    // Reset at cycle 10 of MULT aborts silently; a start on the reset edge is not taken.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'hFFFF_FFFD; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_idle", busy, 0);
    ref_hi = '0;
    ref_lo = '0;

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      exec(ro, ra, rb, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
